// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receive deserializer with mid-bit sampling and framing check
//
// Purpose:
//   Deserializes 8N1 frames from an asynchronous serial line into bytes.
//   The line is synchronized through two flops. The start bit is re-checked
//   at mid-bit. Data bits (LSB first) and the stop bit are each sampled
//   CLKS_PER_BIT clocks after the previous sample.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Enable     asynchronous active-low reset
//   i_RX_Serial  asynchronous serial line, idles high
//   o_RX_DV      one-cycle strobe: o_RX_Byte updated with a good byte
//   o_RX_Byte    last good byte, held between frames
//   o_Frame_Err  one-cycle strobe: stop bit sampled low
//   o_RX_Active  high whenever the FSM is not idle

module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_Clock,
  input  logic       i_Enable,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_RX_Active
);

  localparam int          HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    s_IDLE,
    s_RX_START_BIT,
    s_RX_DATA_BITS,
    s_RX_STOP_BIT,
    s_CLEANUP
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  // Both stages reset to the idle level so leaving reset cannot look like a
  // start edge.
  always_ff @(posedge i_Clock or negedge i_Enable) begin
    if (!i_Enable) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Enable) begin
    if (!i_Enable) begin
      state       <= s_IDLE;
      bit_cnt     <= 16'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      o_RX_DV     <= 1'b0;
      o_RX_Byte   <= 8'h00;
      o_Frame_Err <= 1'b0;
      o_RX_Active <= 1'b0;
    end else begin
      case (state)
        s_IDLE: begin
          bit_cnt <= 16'd0;
          bit_idx <= 3'd0;
          if (!rx_s) begin
            state       <= s_RX_START_BIT;
            o_RX_Active <= 1'b1;
          end else begin
            o_RX_Active <= 1'b0;
          end
        end

        // Re-check the line at mid start bit; a high here means the low was
        // a glitch and the frame is dropped silently.
        s_RX_START_BIT: begin
          if (bit_cnt < HALF_CNT) begin
            bit_cnt <= bit_cnt + 16'd1;
          end else begin
            bit_cnt <= 16'd0;
            if (!rx_s) begin
              state <= s_RX_DATA_BITS;
            end else begin
              state       <= s_IDLE;
              o_RX_Active <= 1'b0;
            end
          end
        end

        // Counter is aligned to mid-bit, so a full bit period later lands
        // on the middle of the next bit.
        s_RX_DATA_BITS: begin
          if (bit_cnt < LAST_CNT) begin
            bit_cnt <= bit_cnt + 16'd1;
          end else begin
            bit_cnt        <= 16'd0;
            shift[bit_idx] <= rx_s;
            if (bit_idx < 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
            end else begin
              bit_idx <= 3'd0;
              state   <= s_RX_STOP_BIT;
            end
          end
        end

        // Leaving at mid stop bit gives half a bit of margin before a
        // back-to-back start edge.
        s_RX_STOP_BIT: begin
          if (bit_cnt < LAST_CNT) begin
            bit_cnt <= bit_cnt + 16'd1;
          end else begin
            bit_cnt <= 16'd0;
            state   <= s_CLEANUP;
            if (rx_s) begin
              o_RX_Byte <= shift;
              o_RX_DV   <= 1'b1;
            end else begin
              o_Frame_Err <= 1'b1;
            end
          end
        end

        s_CLEANUP: begin
          o_RX_DV     <= 1'b0;
          o_Frame_Err <= 1'b0;
          o_RX_Active <= 1'b0;
          state       <= s_IDLE;
        end

        default: begin
          state       <= s_IDLE;
          o_RX_DV     <= 1'b0;
          o_Frame_Err <= 1'b0;
          o_RX_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed self-checking bench for uart_rx_deserializer

module tb_uart_rx_deserializer;

  logic       clk;
  logic       en;
  logic       rx8;
  logic       rx2;
  logic       dv8, fe8, act8;
  logic [7:0] byte8;
  logic       dv2, fe2, act2;
  logic [7:0] byte2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_rx_deserializer #(.CLKS_PER_BIT(8)) dut8 (
    .i_Clock     (clk),
    .i_Enable    (en),
    .i_RX_Serial (rx8),
    .o_RX_DV     (dv8),
    .o_RX_Byte   (byte8),
    .o_Frame_Err (fe8),
    .o_RX_Active (act8)
  );

  uart_rx_deserializer #(.CLKS_PER_BIT(2)) dut2 (
    .i_Clock     (clk),
    .i_Enable    (en),
    .i_RX_Serial (rx2),
    .o_RX_DV     (dv2),
    .o_RX_Byte   (byte2),
    .o_Frame_Err (fe2),
    .o_RX_Active (act2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  int dv8_n = 0, fe8_n = 0, dv8_wide = 0, fe8_wide = 0, both8 = 0;
  int fe8_cyc = 0, act8_rise = 0, act8_fall = 0;
  int dv8_cyc[$];
  logic [7:0] dv8_byte[$];
  logic dv8_p = 1'b0, fe8_p = 1'b0, act8_p = 1'b0;
  int dv2_n = 0, fe2_n = 0, dv2_cyc = 0;

  always @(negedge clk) begin
    if (dv8) begin
      dv8_n = dv8_n + 1;
      dv8_cyc.push_back(cyc);
      dv8_byte.push_back(byte8);
    end
    if (dv8 && dv8_p) dv8_wide = dv8_wide + 1;
    if (fe8) begin
      fe8_n = fe8_n + 1;
      fe8_cyc = cyc;
    end
    if (fe8 && fe8_p) fe8_wide = fe8_wide + 1;
    if (dv8 && fe8) both8 = both8 + 1;
    if (act8 && !act8_p) act8_rise = cyc;
    if (!act8 && act8_p) act8_fall = cyc;
    dv8_p = dv8;
    fe8_p = fe8;
    act8_p = act8;
    if (dv2) begin
      dv2_n = dv2_n + 1;
      dv2_cyc = cyc;
    end
    if (fe2) fe2_n = fe2_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Must be called right after a falling edge; returns likewise. e is the
  // rising edge that first samples the start bit.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic stop,
                            input int cpb, output int e);
    if (sel == 0) rx8 = 1'b0; else rx2 = 1'b0;
    e = cyc + 1;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (sel == 0) rx8 = data[i]; else rx2 = data[i];
      repeat (cpb) @(negedge clk);
    end
    if (sel == 0) rx8 = stop; else rx2 = stop;
    repeat (cpb) @(negedge clk);
    if (sel == 0) rx8 = 1'b1; else rx2 = 1'b1;
  endtask

  int e, e1, e2, n0, f0;
  logic [7:0] v55;

  initial begin
    en  = 1'b0;
    rx8 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_byte", {24'd0, byte8}, 32'h00);
    check("rst_dv", {31'd0, dv8}, 32'd0);
    check("rst_fe", {31'd0, fe8}, 32'd0);
    check("rst_act", {31'd0, act8}, 32'd0);
    check("rst_byte2", {24'd0, byte2}, 32'h00);
    en = 1'b1;
    repeat (5) @(negedge clk);

    // A5 frame
    n0 = dv8_n;
    send_frame(0, 8'hA5, 1'b1, 8, e);
    repeat (10) @(negedge clk);
    check("a5_dv_cnt", dv8_n, n0 + 1);
    check("a5_dv_cyc", dv8_cyc[$], e + 78);
    check("a5_byte", {24'd0, byte8}, 32'hA5);
    check("a5_fe_cnt", fe8_n, 0);
    check("a5_act_rise", act8_rise, e + 2);
    check("a5_act_fall", act8_fall, e + 79);

    // 2-clock low glitch
    n0 = dv8_n;
    rx8 = 1'b0;
    e = cyc + 1;
    repeat (2) @(negedge clk);
    rx8 = 1'b1;
    repeat (20) @(negedge clk);
    check("gl_dv_cnt", dv8_n, n0);
    check("gl_fe_cnt", fe8_n, 0);
    check("gl_byte", {24'd0, byte8}, 32'hA5);
    check("gl_act_rise", act8_rise, e + 2);
    check("gl_idle_at", act8_fall, e + 6);

    // FF with low stop bit
    n0 = dv8_n;
    send_frame(0, 8'hFF, 1'b0, 8, e);
    repeat (20) @(negedge clk);
    check("fe_cnt", fe8_n, 1);
    check("fe_cyc", fe8_cyc, e + 78);
    check("fe_dv_cnt", dv8_n, n0);
    check("fe_byte", {24'd0, byte8}, 32'hA5);

    // back-to-back 3C, C3
    n0 = dv8_n;
    send_frame(0, 8'h3C, 1'b1, 8, e1);
    send_frame(0, 8'hC3, 1'b1, 8, e2);
    repeat (20) @(negedge clk);
    check("b2b_dv_cnt", dv8_n, n0 + 2);
    check("b2b_cyc1", dv8_cyc[$-1], e1 + 78);
    check("b2b_gap", dv8_cyc[$] - dv8_cyc[$-1], 80);
    check("b2b_byte1", {24'd0, dv8_byte[$-1]}, 32'h3C);
    check("b2b_byte2", {24'd0, dv8_byte[$]}, 32'hC3);

    // reset in the middle of data bits of 55
    n0 = dv8_n;
    f0 = fe8_n;
    v55 = 8'h55;
    rx8 = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx8 = v55[i];
      repeat (8) @(negedge clk);
    end
    rx8 = v55[3];
    repeat (4) @(negedge clk);
    en = 1'b0;
    #1;
    check("mid_rst_byte", {24'd0, byte8}, 32'h00);
    check("mid_rst_act", {31'd0, act8}, 32'd0);
    @(negedge clk);
    rx8 = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);
    check("abort_dv_cnt", dv8_n, n0);
    check("abort_fe_cnt", fe8_n, f0);
    send_frame(0, 8'h12, 1'b1, 8, e);
    repeat (10) @(negedge clk);
    check("r12_dv_cnt", dv8_n, n0 + 1);
    check("r12_dv_cyc", dv8_cyc[$], e + 78);
    check("r12_byte", {24'd0, byte8}, 32'h12);

    // CLKS_PER_BIT = 2
    send_frame(1, 8'h81, 1'b1, 2, e);
    repeat (10) @(negedge clk);
    check("c2_dv_cnt", dv2_n, 1);
    check("c2_dv_cyc", dv2_cyc, e + 21);
    check("c2_byte", {24'd0, byte2}, 32'h81);
    check("c2_fe_cnt", fe2_n, 0);

    check("dv_width", dv8_wide, 0);
    check("fe_width", fe8_wide, 0);
    check("dv_fe_overlap", both8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side UART. Deserializes 8N1 frames from the serial line into bytes, using the same CLKS_PER_BIT bit timing as the transmit path.
- Synchronizes the asynchronous line, validates the start bit at mid-bit, samples the data bits at mid-bit, and checks the stop bit.
- Reports each good byte with a one-cycle valid strobe; reports a bad stop bit with a one-cycle framing-error strobe.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per serial bit; legal range 2..65535.
- HALF_BIT, (CLKS_PER_BIT-1)/2 using integer division, mid-bit offset for start-bit validation; localparam, not overridable.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Enable  input  1  asynchronous, active-low reset; low clears all state.
- i_RX_Serial  input  1  asynchronous serial line; idles high.
- o_RX_DV  output  1  one-cycle pulse when o_RX_Byte has been updated with a good byte.
- o_RX_Byte  output  8  last good byte received; holds its value between frames.
- o_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_RX_Active  output  1  high in every state except s_IDLE.

Behaviour:
- Reset (i_Enable low, asynchronous):
  - state = s_IDLE; bit counter, bit index and shift register = 0.
  - o_RX_DV = 0, o_RX_Byte = 8'h00, o_Frame_Err = 0, o_RX_Active = 0.
  - Both synchronizer flops reset to 1 (line idle), so reset release never causes a false start.
- Synchronizer: two flops on i_RX_Serial; only the second flop output (rx_s) is used by the FSM.
- Bit counter is 16 bits. FSM states: s_IDLE, s_RX_START_BIT, s_RX_DATA_BITS, s_RX_STOP_BIT, s_CLEANUP.
- s_IDLE: counter = 0, index = 0. If rx_s = 0, go to s_RX_START_BIT.
- s_RX_START_BIT:
  - Counter < HALF_BIT: counter + 1.
  - Counter = HALF_BIT: counter = 0. Go to s_RX_DATA_BITS if rx_s = 0; otherwise it is a glitch, so return to s_IDLE with no strobe.
- s_RX_DATA_BITS:
  - Counter < CLKS_PER_BIT-1: counter + 1.
  - Otherwise: counter = 0 and shift[index] = rx_s (LSB first).
  - Index < 7: index + 1. Index = 7: index = 0 and go to s_RX_STOP_BIT.
- s_RX_STOP_BIT:
  - Counter < CLKS_PER_BIT-1: counter + 1.
  - Otherwise: counter = 0 and go to s_CLEANUP.
  - If rx_s = 1: o_RX_Byte = shift and o_RX_DV = 1.
  - If rx_s = 0: o_Frame_Err = 1 and o_RX_Byte is unchanged.
- s_CLEANUP: o_RX_DV = 0, o_Frame_Err = 0, go to s_IDLE. Each strobe is therefore exactly 1 cycle.
- Latency: let E be the first rising edge that samples i_RX_Serial low. o_RX_DV or o_Frame_Err is registered at edge E + 3 + HALF_BIT + 9*CLKS_PER_BIT.
- The FSM returns to s_IDLE at mid stop bit, so back-to-back frames with a 1-bit stop are received without loss.
- A start edge arriving while in s_CLEANUP is caught in s_IDLE on the next cycle; worst-case added skew is 1 clock.
- Reset mid-frame: the frame is discarded, no strobe is generated, and o_RX_Byte returns to 8'h00.
- o_RX_DV and o_Frame_Err are never high in the same cycle.
- Line activity during s_CLEANUP or mid-bit is ignored; only samples at the counter boundaries are used.

Test Plan:
- CLKS_PER_BIT=8, send 8'hA5 8N1 -> o_RX_DV pulses once, 1 cycle wide, at E+78; o_RX_Byte = 8'hA5; o_Frame_Err stays 0; o_RX_Active high from E+2 through E+78.
- Send 8'h3C then immediately 8'hC3 (no idle gap) -> two DV pulses 80 cycles apart, carrying 8'h3C then 8'hC3.
- Low glitch of 2 clocks on an idle line -> FSM returns to s_IDLE at E+6; no DV, no error; o_RX_Byte unchanged.
- Frame 8'hFF with the stop bit driven low -> o_Frame_Err pulses 1 cycle at E+78; o_RX_DV = 0; o_RX_Byte keeps the previous value (8'hA5).
- Assert i_Enable low mid-data-bits of 8'h55, release, then send 8'h12 -> no strobe for the aborted frame; o_RX_Byte reads 8'h00 after reset; the next DV carries 8'h12.
- CLKS_PER_BIT=2 (HALF_BIT=0), send 8'h81 -> DV at E+21 with byte 8'h81.
